// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder and its SRAM bank.
package dmem_responder_pkg;
  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int DMEM_BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_RESP
  } dmem_rsp_state_t;

  // Request fields captured at acceptance; the bus is ignored afterwards.
  typedef struct packed {
    logic                     we;
    logic [DMEM_BE_WIDTH-1:0] be;
    logic [DATA_WIDTH-1:0]    wdata;
  } dmem_req_t;
endpackage

// File: rtl/dmem_sram_bank.sv
// Single-port byte-enabled SRAM, one-cycle registered read, no reset.
// A write cycle leaves the read register unchanged.
module dmem_sram_bank
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_WIDTH   = $clog2(DEPTH_WORDS)
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [IDX_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DMEM_BE_WIDTH-1:0] be,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DMEM_BE_WIDTH; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: accepts one request, completes it LATENCY cycles later with a one-cycle dmem_valid.
// One access in flight; the initiator holds dmem_req until dmem_valid, bus is ignored while busy.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    LATENCY     = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dmem_req,
  input  logic                     dmem_we,
  input  logic [ADDR_WIDTH-1:0]    dmem_addr,
  input  logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic [DMEM_BE_WIDTH-1:0] dmem_be,
  output logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     dmem_valid,
  output logic                     dmem_err,
  output logic                     busy,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count
);
  localparam int         IW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  dmem_rsp_state_t state, state_n;
  logic [3:0]      cnt, cnt_n;
  dmem_req_t       lat_q;
  logic [IW-1:0]   lat_idx_q;
  logic            lat_ok_q;

  logic [ADDR_WIDTH:0]   off;
  logic                  bus_ok;
  logic                  accept;
  logic                  unused_lsbs;
  logic                  sram_en, sram_we;
  logic [IW-1:0]         sram_addr;
  logic [DATA_WIDTH-1:0] sram_rdata;

  // One extra bit catches addresses below the base as a borrow instead of a wrap.
  assign off         = {1'b0, dmem_addr} - {1'b0, BASE_ADDR};
  assign bus_ok      = !off[ADDR_WIDTH] &&
                       (off[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(DEPTH_WORDS));
  assign unused_lsbs = ^off[1:0];
  assign accept      = (state == RSP_IDLE) && dmem_req;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      RSP_IDLE: begin
        if (dmem_req) begin
          cnt_n   = LAT_LOAD;
          state_n = (LATENCY == 1) ? RSP_RESP : RSP_WAIT;
        end
      end
      RSP_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = RSP_RESP;
      end
      RSP_RESP: state_n = RSP_IDLE;
      default:  state_n = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RSP_IDLE;
      cnt       <= '0;
      lat_q     <= '0;
      lat_idx_q <= '0;
      lat_ok_q  <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        lat_q     <= '{we: dmem_we, be: dmem_be, wdata: dmem_wdata};
        lat_idx_q <= off[IW+1:2];
        lat_ok_q  <= bus_ok;
      end
      if (dmem_valid) begin
        if (lat_q.we) wr_count <= wr_count + 32'd1;
        else          rd_count <= rd_count + 32'd1;
      end
    end
  end

  // Read is launched on the edge entering RESP so the word is present during RESP;
  // with LATENCY=1 that edge is the accept edge, so the index comes straight off the bus.
  assign sram_we   = (state == RSP_RESP) && lat_q.we && lat_ok_q;
  assign sram_en   = (state_n == RSP_RESP) || sram_we;
  assign sram_addr = accept ? off[IW+1:2] : lat_idx_q;

  dmem_sram_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_WIDTH  (IW)
  ) u_bank (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (sram_addr),
    .wdata(lat_q.wdata),
    .be   (lat_q.be),
    .rdata(sram_rdata)
  );

  assign dmem_valid = (state == RSP_RESP);
  assign dmem_err   = dmem_valid && !lat_ok_q;
  assign dmem_rdata = (dmem_valid && !lat_q.we && lat_ok_q) ? sram_rdata : '0;
  assign busy       = (state != RSP_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder, two instances (LATENCY=2 base 0, LATENCY=1 offset base).
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        valid [2];
  logic        err   [2];
  logic        busy  [2];
  logic [31:0] rdc   [2];
  logic [31:0] wrc   [2];

  int base_a  [2] = '{32'h0, 32'h4000};
  int depth_a [2] = '{1024, 64};
  int lat_a   [2] = '{2, 1};

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model [longint];
  int unsigned m_rd [2];
  int unsigned m_wr [2];
  longint      cyc = 0;
  int          vcount [2];
  int          exp_v  [2];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
    .clk(clk), .rst_n(rst_n), .dmem_req(req[0]), .dmem_we(we[0]), .dmem_addr(addr[0]),
    .dmem_wdata(wdata[0]), .dmem_be(be[0]), .dmem_rdata(rdata[0]), .dmem_valid(valid[0]),
    .dmem_err(err[0]), .busy(busy[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1), .BASE_ADDR(32'h4000)) u_l1 (
    .clk(clk), .rst_n(rst_n), .dmem_req(req[1]), .dmem_we(we[1]), .dmem_addr(addr[1]),
    .dmem_wdata(wdata[1]), .dmem_be(be[1]), .dmem_rdata(rdata[1]), .dmem_valid(valid[1]),
    .dmem_err(err[1]), .busy(busy[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) if (valid[d] === 1'b1) vcount[d]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input int d, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(base_a[d]);
    return (off >= 0) && ((off / 4) < longint'(depth_a[d]));
  endfunction

  function automatic longint mkey(input int d, input logic [31:0] a);
    return longint'(d) * 64'h1_0000_0000 + (longint'(a) - longint'(base_a[d])) / 4;
  endfunction

  // Caller is positioned just after a negedge; returns just after a negedge.
  task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input bit hold,
                        output logic [31:0] got, output longint vcyc);
    int          n;
    bit          ok, known;
    longint      k;
    logic [31:0] exp_rd, nv;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    ok = in_rng(d, a);
    k = ok ? mkey(d, a) : 0;
    known = 1'b1;
    exp_rd = '0;
    if (!w && ok) begin
      if (model.exists(k)) exp_rd = model[k];
      else known = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (valid[d] !== 1'b1 && n < 40) begin
        we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
      end
    end while (valid[d] !== 1'b1 && n < 40);
    vcyc = cyc;
    got = rdata[d];
    chk("latency", 64'(n), 64'(lat_a[d]));
    chk("busy_resp", 64'(busy[d]), 64'd1);
    chk("err", 64'(err[d]), 64'(!ok));
    if (known) chk("rdata", 64'(rdata[d]), 64'(exp_rd));
    if (w && ok) begin
      nv = model.exists(k) ? model[k] : 32'hx;
      for (int i = 0; i < 4; i++) if (b[i]) nv[8*i +: 8] = wd[8*i +: 8];
      model[k] = nv;
    end
    if (w) m_wr[d]++; else m_rd[d]++;
    exp_v[d]++;
    if (!hold) req[d] = 1'b0;
    @(negedge clk);
    chk("valid_one_cycle", 64'(valid[d]), 64'd0);
    chk("busy_idle", 64'(busy[d]), 64'd0);
    chk("rd_count", 64'(rdc[d]), 64'(m_rd[d]));
    chk("wr_count", 64'(wrc[d]), 64'(m_wr[d]));
  endtask

  initial begin
    logic [31:0] g, ra;
    longint      v0, v1, v2;
    int          sel;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 0; wdata[d] = 0; be[d] = 0;
      m_rd[d] = 0; m_wr[d] = 0; vcount[d] = 0; exp_v[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_valid", 64'(valid[d]), 64'd0);
      chk("reset_busy", 64'(busy[d]), 64'd0);
      chk("reset_err", 64'(err[d]), 64'd0);
      chk("reset_rdata", 64'(rdata[d]), 64'd0);
      chk("reset_rd_count", 64'(rdc[d]), 64'd0);
      chk("reset_wr_count", 64'(wrc[d]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Full store then load, LATENCY=2.
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, g, v0);
    access(0, 0, 32'h10, 32'h0, 4'b0000, 0, g, v0);
    chk("t1_rdata", 64'(g), 64'hDEADBEEF);
    chk("t1_counts", {32'(rdc[0]), 32'(wrc[0])}, {32'd1, 32'd1});

    // Partial-byte store and be=0 no-op.
    access(0, 1, 32'h14, 32'h11223344, 4'b1111, 0, g, v0);
    access(0, 1, 32'h14, 32'hAAAAAAAA, 4'b0100, 0, g, v0);
    access(0, 0, 32'h14, 32'h0, 4'b0000, 0, g, v0);
    chk("t2_merge", 64'(g), 64'h11AA3344);
    access(0, 1, 32'h14, 32'h55555555, 4'b0000, 0, g, v0);
    access(0, 0, 32'h14, 32'h0, 4'b0000, 0, g, v0);
    chk("t2_be0", 64'(g), 64'h11AA3344);

    // Three loads with req held high throughout.
    access(0, 0, 32'h10, 32'h0, 4'b0, 1, g, v0);
    access(0, 0, 32'h14, 32'h0, 4'b0, 1, g, v1);
    access(0, 0, 32'h10, 32'h0, 4'b0, 0, g, v2);
    chk("t3_gap1", 64'(v1 - v0), 64'd3);
    chk("t3_gap2", 64'(v2 - v1), 64'd3);
    chk("t3_last_rdata", 64'(g), 64'hDEADBEEF);

    // Window end: index DEPTH_WORDS must not alias word 0.
    access(0, 1, 32'h0, 32'hCAFE0000, 4'b1111, 0, g, v0);
    access(0, 0, 32'h1000, 32'h0, 4'b0, 0, g, v0);
    chk("t4_oor_rdata", 64'(g), 64'd0);
    access(0, 1, 32'h1000, 32'h12345678, 4'b1111, 0, g, v0);
    access(0, 0, 32'h0, 32'h0, 4'b0, 0, g, v0);
    chk("t4_no_alias", 64'(g), 64'hCAFE0000);

    // Reset during WAIT of a store aborts it.
    access(0, 1, 32'h20, 32'h5, 4'b1111, 0, g, v0);
    req[0] = 1; we[0] = 1; addr[0] = 32'h20; wdata[0] = 32'h99; be[0] = 4'b1111;
    @(negedge clk);
    chk("t5_busy_wait", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    req[0] = 0;
    for (int d = 0; d < 2; d++) begin
      chk("t5_valid", 64'(valid[d]), 64'd0);
      chk("t5_busy", 64'(busy[d]), 64'd0);
      chk("t5_counts", {32'(rdc[d]), 32'(wrc[d])}, 64'd0);
      m_rd[d] = 0; m_wr[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 0, 32'h20, 32'h0, 4'b0, 0, g, v0);
    chk("t5_old_value", 64'(g), 64'h5);

    // LATENCY=1 back-to-back store/load.
    access(1, 1, 32'h4008, 32'hA5A50F0F, 4'b1111, 0, g, v0);
    access(1, 0, 32'h4008, 32'h0, 4'b0, 0, g, v1);
    chk("t6_gap", 64'(v1 - v0), 64'd2);
    chk("t6_rdata", 64'(g), 64'hA5A50F0F);
    access(1, 0, 32'h3FFC, 32'h0, 4'b0, 0, g, v0);
    chk("t6_below_base", 64'(g), 64'd0);

    // Randomized traffic over a small word window plus out-of-range probes.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        access(d, 1, base_a[d] + 4 * i, $urandom, 4'b1111, 0, g, v0);
      for (int i = 0; i < 60; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 8)       ra = base_a[d] + 4 * $urandom_range(0, 15);
        else if (sel == 8) ra = base_a[d] + 4 * depth_a[d] + 4 * $urandom_range(0, 3);
        else               ra = (d == 0) ? 32'hFFFF_FFFC : 32'h0;
        access(d, 1'($urandom), ra, $urandom, 4'($urandom), 1'($urandom), g, v0);
      end
      req[d] = 0;
      @(negedge clk);
    end

    for (int d = 0; d < 2; d++) chk("valid_total", 64'(vcount[d]), 64'(exp_v[d]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
